// File: rtl/result_if.sv
// Bundles the capture-side and read-back signals of the result store.
// master: the CPU/bench side that drives captures and read addresses.
// slave: the result store itself, which returns registered state.
interface result_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              eo;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] in;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [DATA_W-1:0] last_data;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] wr_count;
    logic              any_written;

    modport master (
        output eo, addr, in, rd_addr,
        input  rd_data, rd_valid, last_data, last_addr, wr_count, any_written
    );

    modport slave (
        input  eo, addr, in, rd_addr,
        output rd_data, rd_valid, last_data, last_addr, wr_count, any_written
    );
endinterface

// File: rtl/result.sv
// Result-capture store: logs every CPU output byte into a 2**ADDR_W x DATA_W memory.
// Latency: capture visible on the next edge; read-back is 1 cycle, write-first on collision.
// No backpressure: a capture is accepted on every edge with eo high.
module result #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic     clk,
    input  logic     rst,
    result_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    // Memory contents are never reset; the written flags say which words are real.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  written_q,     written_d;
    logic [DATA_W-1:0] rd_data_q,     rd_data_d;
    logic              rd_valid_q,    rd_valid_d;
    logic [DATA_W-1:0] last_data_q,   last_data_d;
    logic [ADDR_W-1:0] last_addr_q,   last_addr_d;
    logic [ADDR_W-1:0] wr_count_q,    wr_count_d;
    logic              any_written_q, any_written_d;
    logic              rd_hit;

    // Next-state: capture bookkeeping plus write-first read-back.
    always_comb begin
        written_d     = written_q;
        last_data_d   = last_data_q;
        last_addr_d   = last_addr_q;
        wr_count_d    = wr_count_q;
        any_written_d = any_written_q;
        if (bus.eo) begin
            written_d[bus.addr] = 1'b1;
            last_data_d         = bus.in;
            last_addr_d         = bus.addr;
            wr_count_d          = wr_count_q + ADDR_W'(1);
            any_written_d       = 1'b1;
        end
        // A capture to the address being read this edge must be seen immediately.
        rd_hit     = bus.eo && (bus.addr == bus.rd_addr);
        rd_data_d  = rd_hit ? bus.in : mem_q[bus.rd_addr];
        rd_valid_d = rd_hit | written_q[bus.rd_addr];
    end

    // Control and read registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written_q     <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            last_data_q   <= '0;
            last_addr_q   <= '0;
            wr_count_q    <= '0;
            any_written_q <= 1'b0;
        end else begin
            written_q     <= written_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            last_data_q   <= last_data_d;
            last_addr_q   <= last_addr_d;
            wr_count_q    <= wr_count_d;
            any_written_q <= any_written_d;
        end
    end

    // Storage array: plain write port, held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && bus.eo) begin
            mem_q[bus.addr] <= bus.in;
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.last_data   = last_data_q;
    assign bus.last_addr   = last_addr_q;
    assign bus.wr_count    = wr_count_q;
    assign bus.any_written = any_written_q;
endmodule

// File: tb/tb_result.sv
// Self-checking bench for the result store.
// Reference model: plain arrays updated at each edge from the capture rules.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
module tb_result;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    result_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    result #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] ref_mem [256];
    bit         ref_written [256];
    logic [7:0] ref_last_data;
    logic [7:0] ref_last_addr;
    int         ref_count;
    bit         ref_any;
    logic [7:0] exp_rd_data;
    bit         exp_rd_valid;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_written[i] = 1'b0;
        ref_last_data = 8'd0;
        ref_last_addr = 8'd0;
        ref_count     = 0;
        ref_any       = 1'b0;
        exp_rd_data   = 8'd0;
        exp_rd_valid  = 1'b0;
    endtask

    // Advance one edge, apply the capture rules to the model, then settle.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (bus.eo) begin
                ref_mem[bus.addr]     = bus.in;
                ref_written[bus.addr] = 1'b1;
                ref_last_data         = bus.in;
                ref_last_addr         = bus.addr;
                ref_count             = (ref_count + 1) % 256;
                ref_any               = 1'b1;
            end
            exp_rd_valid = ref_written[bus.rd_addr];
            exp_rd_data  = ref_mem[bus.rd_addr];
        end
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] waddr [4];
        rst = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        #2;
        tests_run++;
        if (bus.rd_data !== 8'd0 || bus.rd_valid !== 1'b0 || bus.last_data !== 8'd0 ||
            bus.last_addr !== 8'd0 || bus.wr_count !== 8'd0 || bus.any_written !== 1'b0) begin
            tests_failed++;
            $display("FAIL power_on_reset: got rd=%h v=%b ld=%h la=%h cnt=%h any=%b, expected all zero",
                     bus.rd_data, bus.rd_valid, bus.last_data, bus.last_addr, bus.wr_count, bus.any_written);
        end
        #1 rst = 1'b0;
        // Populate some state, then reset mid-cycle.
        bus.eo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            waddr[i] = 8'h40 + 8'(i * 7);
            bus.addr = waddr[i];
            bus.in   = 8'($urandom_range(1, 255));
            bus.rd_addr = waddr[i];
            tick();
        end
        bus.eo = 1'b0;
        tests_run++;
        if (bus.wr_count !== 8'd4 || bus.rd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_state: got cnt=%h v=%b, expected cnt=04 v=1", bus.wr_count, bus.rd_valid);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if (bus.rd_data !== 8'd0 || bus.rd_valid !== 1'b0 || bus.last_data !== 8'd0 ||
            bus.last_addr !== 8'd0 || bus.wr_count !== 8'd0 || bus.any_written !== 1'b0) begin
            tests_failed++;
            $display("FAIL midcycle_reset: got rd=%h v=%b ld=%h la=%h cnt=%h any=%b, expected all zero",
                     bus.rd_data, bus.rd_valid, bus.last_data, bus.last_addr, bus.wr_count, bus.any_written);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.rd_addr = waddr[i];
            tick();
            tests_run++;
            if (bus.rd_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL post_reset_valid[%0h]: got %b expected 0", waddr[i], bus.rd_valid);
            end
        end
    endtask

    task automatic test_basic_capture();
        bus.eo = 1'b1; bus.in = 8'd50; bus.addr = 8'd0; bus.rd_addr = 8'd9;
        tick(); tick();
        bus.addr = 8'd1;
        tick(); tick();
        bus.eo = 1'b0; bus.addr = 8'd2; bus.rd_addr = 8'd2;
        tick();
        tests_run++;
        if (bus.rd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_unwritten_valid: got %b expected 0", bus.rd_valid);
        end
        tests_run++;
        if (bus.last_data !== 8'd50 || bus.last_addr !== 8'd1 || bus.wr_count !== 8'd4 || bus.any_written !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_regs: got ld=%0d la=%0d cnt=%0d any=%b expected 50 1 4 1",
                     bus.last_data, bus.last_addr, bus.wr_count, bus.any_written);
        end
        for (int a = 0; a < 2; a++) begin
            bus.rd_addr = 8'(a);
            tick();
            tests_run++;
            if (bus.rd_data !== 8'd50 || bus.rd_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL basic_mem[%0d]: got %0d v=%b expected 50 v=1", a, bus.rd_data, bus.rd_valid);
            end
        end
    endtask

    task automatic test_read_latency();
        bus.eo = 1'b1; bus.addr = 8'h10; bus.in = 8'hA5; bus.rd_addr = 8'h11;
        tick();
        bus.eo = 1'b0; bus.rd_addr = 8'h10;
        #2;
        tests_run++;
        if (bus.rd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_early: got v=%b before edge, expected 0", bus.rd_valid);
        end
        @(negedge clk);
        tick();
        tests_run++;
        if (bus.rd_data !== 8'hA5 || bus.rd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_read: got %h v=%b expected a5 v=1", bus.rd_data, bus.rd_valid);
        end
    endtask

    task automatic test_collision();
        bus.eo = 1'b1; bus.addr = 8'h20; bus.rd_addr = 8'h20; bus.in = 8'h3C;
        tick();
        bus.eo = 1'b0;
        tests_run++;
        if (bus.rd_data !== 8'h3C || bus.rd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL collision: got %h v=%b expected 3c v=1", bus.rd_data, bus.rd_valid);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] c0;
        c0 = bus.wr_count;
        bus.eo = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.addr    = 8'($urandom_range(0, 255));
            bus.in      = 8'($urandom_range(0, 255));
            bus.rd_addr = ($urandom_range(0, 3) == 0) ? bus.addr : 8'($urandom_range(0, 255));
            tick();
            tests_run++;
            if (bus.wr_count !== 8'(ref_count) || bus.any_written !== 1'b1 ||
                bus.rd_valid !== exp_rd_valid || (exp_rd_valid && bus.rd_data !== exp_rd_data)) begin
                tests_failed++;
                $display("FAIL wrap_step[%0d]: got cnt=%h any=%b rd=%h v=%b expected cnt=%h any=1 rd=%h v=%b",
                         i, bus.wr_count, bus.any_written, bus.rd_data, bus.rd_valid,
                         8'(ref_count), exp_rd_data, exp_rd_valid);
            end
        end
        bus.eo = 1'b0;
        tests_run++;
        if (bus.wr_count !== c0 || bus.any_written !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_final: got cnt=%h any=%b expected cnt=%h any=1", bus.wr_count, bus.any_written, c0);
        end
    endtask

    task automatic test_idle();
        logic [7:0] ld, la, cnt;
        ld = bus.last_data; la = bus.last_addr; cnt = bus.wr_count;
        bus.eo = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.addr = 8'($urandom_range(0, 255));
            bus.in   = 8'($urandom_range(0, 255));
            tick();
            tests_run++;
            if (bus.last_data !== ld || bus.last_addr !== la || bus.wr_count !== cnt) begin
                tests_failed++;
                $display("FAIL idle_hold[%0d]: got ld=%h la=%h cnt=%h expected %h %h %h",
                         i, bus.last_data, bus.last_addr, bus.wr_count, ld, la, cnt);
            end
        end
        // Full sweep: every location still matches what the model last stored.
        for (int a = 0; a < 256; a++) begin
            bus.rd_addr = 8'(a);
            bus.addr    = 8'($urandom_range(0, 255));
            bus.in      = 8'($urandom_range(0, 255));
            tick();
            tests_run++;
            if (bus.rd_valid !== exp_rd_valid || (exp_rd_valid && bus.rd_data !== exp_rd_data)) begin
                tests_failed++;
                $display("FAIL idle_mem[%0h]: got %h v=%b expected %h v=%b",
                         a, bus.rd_data, bus.rd_valid, exp_rd_data, exp_rd_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bus.eo      = 1'($urandom_range(0, 1));
            bus.addr    = 8'($urandom_range(0, 15));
            bus.in      = 8'($urandom_range(0, 255));
            bus.rd_addr = 8'($urandom_range(0, 15));
            tick();
            tests_run++;
            if (bus.last_data !== ref_last_data || bus.last_addr !== ref_last_addr ||
                bus.wr_count !== 8'(ref_count) || bus.any_written !== ref_any ||
                bus.rd_valid !== exp_rd_valid || (exp_rd_valid && bus.rd_data !== exp_rd_data)) begin
                tests_failed++;
                $display("FAIL random[%0d]: got ld=%h la=%h cnt=%h rd=%h v=%b expected ld=%h la=%h cnt=%h rd=%h v=%b",
                         i, bus.last_data, bus.last_addr, bus.wr_count, bus.rd_data, bus.rd_valid,
                         ref_last_data, ref_last_addr, 8'(ref_count), exp_rd_data, exp_rd_valid);
            end
        end
        bus.eo = 1'b0;
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        bus.eo = 1'b0; bus.addr = 8'd0; bus.in = 8'd0; bus.rd_addr = 8'd0;
        model_reset();
        test_reset();
        test_basic_capture();
        test_read_latency();
        test_collision();
        test_wrap();
        test_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded 1ms, expected completion");
        $fatal(1, "timeout");
    end
endmodule
